// File: rtl/mac_operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : mac_operand_loader
// Brief    : Debounced keypad/button front end that loads FP16 operands,
//            issues a valid/ready MAC request and captures the result.
// Revision : 1.0 - initial release
// ============================================================================
module mac_operand_loader #(
    parameter int DBNC_CYCLES    = 500000,
    parameter int DBNC_W         = 20,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] key_data,
    input  logic        btn_a,
    input  logic        btn_b,
    input  logic        btn_go,
    input  logic        btn_clr,
    output logic [15:0] mac_a,
    output logic [15:0] mac_b,
    output logic        mac_valid,
    input  logic        mac_ready,
    output logic        mac_clr,
    input  logic [15:0] mac_res,
    input  logic        mac_res_valid,
    output logic [15:0] disp_data,
    output logic [1:0]  disp_sel,
    output logic        led_a_ok,
    output logic        led_b_ok,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    localparam logic [DBNC_W-1:0] C_DBNC_MAX = DBNC_W'(DBNC_CYCLES - 1);
    localparam logic [TO_W-1:0]   C_TO_MAX   = TO_W'(TIMEOUT_CYCLES - 1);

    logic [3:0] w_btn;
    logic [3:0] w_ev;

    assign w_btn = {btn_clr, btn_go, btn_b, btn_a};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dbnc
            logic              r_s1;
            logic              r_s2;
            logic              r_stable;
            logic              r_stable_d;
            logic              r_ev;
            logic [DBNC_W-1:0] r_cnt;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_s1       <= 1'b0;
                    r_s2       <= 1'b0;
                    r_stable   <= 1'b0;
                    r_stable_d <= 1'b0;
                    r_ev       <= 1'b0;
                    r_cnt      <= '0;
                end else begin
                    r_s1       <= w_btn[gi];
                    r_s2       <= r_s1;
                    r_stable_d <= r_stable;
                    r_ev       <= r_stable & ~r_stable_d;
                    // Any sample matching the accepted level restarts the count
                    if (r_s2 != r_stable) begin
                        if (r_cnt == C_DBNC_MAX) begin
                            r_stable <= r_s2;
                            r_cnt    <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end
            end

            assign w_ev[gi] = r_ev;
        end
    endgenerate

    state_t      r_state,     w_state_nxt;
    logic [15:0] r_a,         w_a_nxt;
    logic [15:0] r_b,         w_b_nxt;
    logic [15:0] r_res,       w_res_nxt;
    logic        r_led_a,     w_led_a_nxt;
    logic        r_led_b,     w_led_b_nxt;
    logic        r_err,       w_err_nxt;
    logic [1:0]  r_disp_sel,  w_disp_sel_nxt;
    logic        r_mac_valid, w_mac_valid_nxt;
    logic [TO_W-1:0] r_to_cnt, w_to_cnt_nxt;
    logic [15:0] r_key_prev;
    logic [15:0] r_disp_data, w_disp_mux;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_led_a     <= 1'b0;
            r_led_b     <= 1'b0;
            r_err       <= 1'b0;
            r_disp_sel  <= '0;
            r_mac_valid <= 1'b0;
            r_to_cnt    <= '0;
            r_key_prev  <= '0;
            r_disp_data <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_res       <= w_res_nxt;
            r_led_a     <= w_led_a_nxt;
            r_led_b     <= w_led_b_nxt;
            r_err       <= w_err_nxt;
            r_disp_sel  <= w_disp_sel_nxt;
            r_mac_valid <= w_mac_valid_nxt;
            r_to_cnt    <= w_to_cnt_nxt;
            r_key_prev  <= key_data;
            r_disp_data <= w_disp_mux;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_a_nxt         = r_a;
        w_b_nxt         = r_b;
        w_res_nxt       = r_res;
        w_led_a_nxt     = r_led_a;
        w_led_b_nxt     = r_led_b;
        w_err_nxt       = r_err;
        w_disp_sel_nxt  = r_disp_sel;
        w_mac_valid_nxt = r_mac_valid;
        w_to_cnt_nxt    = r_to_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_ev[3]) begin
                    w_state_nxt = ST_CLEAR;
                end else begin
                    if (key_data != r_key_prev) w_disp_sel_nxt = 2'd0;
                    if (w_ev[0]) begin
                        w_a_nxt        = key_data;
                        w_led_a_nxt    = 1'b1;
                        w_disp_sel_nxt = 2'd1;
                        w_err_nxt      = 1'b0;
                    end
                    if (w_ev[1]) begin
                        w_b_nxt        = key_data;
                        w_led_b_nxt    = 1'b1;
                        w_disp_sel_nxt = 2'd2;
                        w_err_nxt      = 1'b0;
                    end
                    if (w_ev[2]) begin
                        if (r_led_a && r_led_b) begin
                            w_state_nxt     = ST_ISSUE;
                            w_mac_valid_nxt = 1'b1;
                            w_to_cnt_nxt    = '0;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end
                end
            end
            // A completed handshake or result on the last allowed cycle wins
            // over the abort; both leave at the same edge, so the bound holds.
            ST_ISSUE: begin
                w_to_cnt_nxt = r_to_cnt + 1'b1;
                if (r_mac_valid && mac_ready) begin
                    w_mac_valid_nxt = 1'b0;
                    w_state_nxt     = ST_WAIT;
                end else if (r_to_cnt == C_TO_MAX) begin
                    w_mac_valid_nxt = 1'b0;
                    w_err_nxt       = 1'b1;
                    w_state_nxt     = ST_IDLE;
                end
            end
            ST_WAIT: begin
                w_to_cnt_nxt = r_to_cnt + 1'b1;
                if (mac_res_valid) begin
                    w_res_nxt      = mac_res;
                    w_disp_sel_nxt = 2'd3;
                    w_state_nxt    = ST_IDLE;
                end else if (r_to_cnt == C_TO_MAX) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                w_a_nxt        = '0;
                w_b_nxt        = '0;
                w_res_nxt      = '0;
                w_led_a_nxt    = 1'b0;
                w_led_b_nxt    = 1'b0;
                w_err_nxt      = 1'b0;
                w_disp_sel_nxt = 2'd0;
                w_state_nxt    = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_disp_mux = key_data;
        case (r_disp_sel)
            2'd1:    w_disp_mux = r_a;
            2'd2:    w_disp_mux = r_b;
            2'd3:    w_disp_mux = r_res;
            default: w_disp_mux = key_data;
        endcase
    end

    assign mac_a     = r_a;
    assign mac_b     = r_b;
    assign mac_valid = r_mac_valid;
    assign mac_clr   = (r_state == ST_CLEAR);
    assign disp_data = r_disp_data;
    assign disp_sel  = r_disp_sel;
    assign led_a_ok  = r_led_a;
    assign led_b_ok  = r_led_b;
    assign busy      = (r_state != ST_IDLE);
    assign err       = r_err;

endmodule
`default_nettype wire

// File: doc/mac_operand_loader.md
Name: mac_operand_loader

Overview:
- Sits directly downstream of the keypad scanner. Consumes its 16-bit shifted hex entry register (key_data) plus four raw push-buttons.
- Latches the entered value as FP16 operand A or B, issues a valid/ready transaction to the floating-point MAC, and captures the MAC result.
- Drives a 16-bit display word and status LEDs, so the board can enter, run and inspect MAC operations without a host.

Parameters:
- DBNC_CYCLES, 500000, consecutive stable cycles before a button level change is accepted (10 ms at 50 MHz).
- DBNC_W, 20, width of debounce counters; must hold DBNC_CYCLES-1.
- TIMEOUT_CYCLES, 1024, maximum cycles spent in ISSUE+WAIT before abort.
- TO_W, 11, width of timeout counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- key_data  in  16  keypad entry register (last four hex digits, newest in [3:0])
- btn_a  in  1  raw button, active-high, asynchronous: load operand A
- btn_b  in  1  raw button: load operand B
- btn_go  in  1  raw button: start MAC operation
- btn_clr  in  1  raw button: clear operands, result and MAC accumulator
- mac_a  out  16  operand A to MAC
- mac_b  out  16  operand B to MAC
- mac_valid  out  1  operation request
- mac_ready  in  1  MAC accepts request
- mac_clr  out  1  one-cycle accumulator clear pulse
- mac_res  in  16  MAC result
- mac_res_valid  in  1  one-cycle result strobe
- disp_data  out  16  word for 4-digit display
- disp_sel  out  2  display source: 0 keypad, 1 A, 2 B, 3 result
- led_a_ok  out  1  operand A loaded
- led_b_ok  out  1  operand B loaded
- busy  out  1  state != IDLE
- err  out  1  sticky error flag

Behaviour:
- Reset (rst=0, async): every output and register is 0. State=IDLE. Debounce "stable" levels are 0.
- Button conditioning, per button:
  - 2-flop synchroniser producing s.
  - When s != stable: cnt increments. When cnt==DBNC_CYCLES-1 and s != stable: stable<=s and cnt<=0.
  - When s == stable: cnt<=0.
  - ev is a registered one-cycle pulse, set in the cycle after stable goes 0->1.
  - A glitch shorter than DBNC_CYCLES never produces ev. Release produces no event.
- FSM states: IDLE, ISSUE, WAIT, CLEAR.
- IDLE:
  - ev_a: a_reg<=key_data, led_a_ok<=1, disp_sel<=1, err<=0.
  - ev_b: likewise for b_reg, led_b_ok and disp_sel<=2.
  - ev_a and ev_b in the same cycle: both captured; disp_sel<=2.
  - ev_go with led_a_ok&led_b_ok: go to ISSUE, assert mac_valid, clear the timeout counter.
  - ev_go without both operands loaded: err<=1 and stay in IDLE.
  - ev_clr: go to CLEAR. ev_clr has priority over every other event in the same cycle.
  - key_data differing from its previous-cycle value: disp_sel<=0.
- ISSUE:
  - mac_a=a_reg and mac_b=b_reg throughout; mac_valid is held high.
  - mac_valid&mac_ready at a clock edge: transfer occurs; mac_valid<=0, go to WAIT.
  - mac_ready already high on the first ISSUE cycle gives a single-cycle transfer.
- WAIT:
  - mac_res_valid: res_reg<=mac_res, disp_sel<=3, go to IDLE.
  - Operands and led_*_ok are retained, so repeated go accumulates again.
  - mac_res_valid in any other state is ignored.
- Timeout:
  - Counter runs in ISSUE and WAIT.
  - Reaching TIMEOUT_CYCLES-1: mac_valid<=0, err<=1, go to IDLE; res_reg unchanged.
- CLEAR (one cycle):
  - mac_clr=1.
  - a_reg, b_reg, res_reg, led_a_ok, led_b_ok, err and disp_sel are cleared to 0.
  - Return to IDLE.
- All button events arriving while not in IDLE are dropped, not queued. This includes clr.
- disp_data is registered, one cycle after its source/selection: key_data, a_reg, b_reg or res_reg per disp_sel.
- err is cleared only by ev_a, ev_b, ev_clr or reset.
- busy is combinational from the state register.
- Reset asserted mid-operation: immediately returns all state to reset values; mac_valid drops asynchronously.

Test Plan (DBNC_CYCLES=4, TIMEOUT_CYCLES=32 in bench):
- Reset check: after reset, all outputs are 0 and disp_data follows key_data=0x1234 one cycle later with disp_sel=0.
- Full operation:
  - key_data=0x3C00, press btn_a 10 cycles: a_reg=0x3C00, led_a_ok=1, disp_data=0x3C00.
  - key_data=0x4000, press btn_b: B loaded.
  - Press btn_go, mac_ready held low 3 cycles: mac_valid stays high with mac_a=0x3C00 and mac_b=0x4000.
  - Return mac_res=0x4000 with mac_res_valid 5 cycles after the transfer: disp_sel=3, disp_data=0x4000, busy=0.
- Bounce: 3-cycle btn_a pulses separated by 1 cycle produce no load. A following 8-cycle press produces exactly one load.
- Error path:
  - After reset, btn_a only, then btn_go: err=1 and no mac_valid.
  - Then btn_b: err=0.
  - Then btn_go with mac_ready never asserted: err=1 exactly 32 cycles after ISSUE entry, mac_valid=0, state IDLE.
- Clear and drop:
  - btn_clr while IDLE with operands loaded: mac_clr is high for exactly one cycle, LEDs go to 0, disp_data=key_data.
  - btn_clr pressed during WAIT is dropped: the subsequent result is still captured.
- Async reset asserted in ISSUE: mac_valid falls with no clock edge, and after release the state is IDLE with all registers 0.
